uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Byte-wide UART transmitter. It serialises 8-bit data onto a single line as start, 8 data bits LSB first, optional parity, and 1 or 2 stop bits. It pairs with the team's UART receiver on the opposite end of the link. A one-entry holding register lets the host queue the next byte while the current frame shifts out, so consecutive frames go out back-to-back with no idle gap.

Parameters:
clk_freq, 50000000, input clock frequency in Hz
baud_rate, 9600, line bit rate; clks_per_bit = clk_freq / baud_rate (integer divide)
parity_en, 0, 1 = insert a parity bit after d7
parity_odd, 0, 0 = even parity, 1 = odd parity (ignored when parity_en=0)
stop_bits, 1, number of stop bits, legal values 1 or 2

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
tx_data  input  8  byte to send, sampled when the byte is accepted
tx_start  input  1  request to send tx_data; accepted on a rising edge where tx_start && tx_ready
tx_ready  output  1  high while the holding register is empty (a new byte can be accepted)
tx_line  output  1  serial output, idles high
tx_busy  output  1  high while any frame bit is being driven
tx_done  output  1  one-cycle pulse after each frame's final stop bit completes

Behaviour:
- Reset (reset_n=0, asynchronous): tx_line=1, tx_ready=1, tx_busy=0, tx_done=0, FSM=IDLE, counters=0. The holding register is cleared.
- Reset mid-frame: the line returns high immediately and any queued byte is discarded. No tx_done pulse is generated.
- Bit timing: each bit is held exactly clks_per_bit cycles, counted by a 16-bit counter. Legal range: 2 <= clks_per_bit <= 65535.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on acceptance, or when the holding register is valid.
  - START -> DATA after 1 bit time.
  - DATA: 8 bit times, d0 first, bit index 0..7. Then DATA -> PARITY if parity_en, else DATA -> STOP.
  - PARITY: 1 bit time. The bit is XOR of the 8 data bits, inverted when parity_odd=1.
  - STOP: stop_bits bit times, line high.
- Frame length is (10 + parity_en + stop_bits - 1) * clks_per_bit cycles.
- Acceptance at edge N with FSM in IDLE:
  - the byte loads into the shift register;
  - tx_line=0 and tx_busy=1 from edge N;
  - tx_ready stays 1.
- Acceptance while a frame is active: the byte goes to the holding register and tx_ready=0 from edge N.
- tx_start while tx_ready=0 is ignored. The held byte is not overwritten.
- End of frame at edge M (last stop-bit cycle completes), holding register valid:
  - the held byte loads at edge M and its start bit begins at edge M (zero idle cycles);
  - tx_ready=1 from edge M;
  - tx_busy stays 1.
- End of frame at edge M, holding register empty, tx_start asserted at edge M: treated as an IDLE acceptance, so the new frame starts at edge M.
- End of frame at edge M, nothing pending: FSM -> IDLE, tx_line=1, tx_busy=0.
- tx_done is high for exactly one cycle following edge M for every frame, including back-to-back frames.
- tx_data is captured only at acceptance; later changes on tx_data do not affect a frame in flight.
- All outputs are registered, so tx_line has no glitches.

Test Plan:
All scenarios use clk_freq=1000000 and baud_rate=100000 (10 clks/bit).
1. Single byte: send 0xA5, 8N1 -> tx_line sequence 0,1,0,1,0,0,1,0,1,1, each level held 10 cycles. tx_busy high for 100 cycles. One tx_done pulse at cycle 100. tx_ready stays 1 throughout.
2. Parity: send 0xA5 with parity_en=1 -> parity bit 0 for even and 1 for parity_odd=1. Frame is 110 cycles. Send 0x07 even -> parity bit 1.
3. Back-to-back: send 0x55, then 0x0F one cycle later.
   - tx_ready drops after the second accept.
   - The second start bit begins exactly 100 cycles after the first.
   - 200 cycles continuous busy, two tx_done pulses, tx_ready returns to 1 at cycle 100.
   - A third tx_start (0xFF) during cycles 2..99 is ignored, and 0x0F is still sent.
4. Two stop bits: stop_bits=2, send 0x00 -> line low for 90 cycles, then high for 20 cycles. tx_done at cycle 110.
5. Reset mid-frame: assert reset_n=0 during d3 of 0xC3 with a byte queued -> tx_line=1 asynchronously, tx_ready=1, tx_busy=0. No tx_done. After release the line stays idle high until a new tx_start.
6. Boundary accept: pulse tx_start with 0x3C in the exact last cycle of a frame, with the holding register empty -> new start bit at that edge, zero gap, tx_ready stays 1.

Source files
------------

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: start, 8 data bits LSB first, optional parity, 1 or 2 stops.
// A one-entry holding register lets the next byte follow the current frame with no idle gap.
//
// state  | meaning
// IDLE   | line high, waiting for a byte
// START  | driving the start bit (low)
// DATA   | shifting d0..d7 out, LSB first
// PARITY | driving the parity bit
// STOP   | driving stop bit(s), line high
module uart_tx #(
    parameter int clk_freq   = 50000000,
    parameter int baud_rate  = 9600,
    parameter int parity_en  = 0,
    parameter int parity_odd = 0,
    parameter int stop_bits  = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       tx_line,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam int          CPB       = clk_freq / baud_rate;
    localparam logic [15:0] BIT_LAST  = 16'(CPB - 1);
    localparam logic        PAR_EN    = (parity_en != 0);
    localparam logic        PAR_ODD   = (parity_odd != 0);
    localparam logic        STOP_LAST = (stop_bits == 2);

    logic [2:0]  state;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        parity_bit;
    logic        stop_cnt;
    logic [7:0]  hold_data;

    logic        bit_end;
    logic        frame_end;
    logic        can_load;
    logic        load_hold;
    logic        load_new;
    logic        load;
    logic [7:0]  load_data;
    logic        queue;

    always_comb begin
        bit_end   = (bit_cnt == 16'd0);
        frame_end = (state == STOP) && bit_end && !stop_cnt;
        can_load  = (state == IDLE) || frame_end;
        load_hold = can_load && !tx_ready;
        load_new  = can_load && tx_ready && tx_start;
        load      = load_hold || load_new;
        load_data = load_hold ? hold_data : tx_data;
        // Once a frame is in flight, an accepted byte waits in the holding register.
        queue     = tx_start && tx_ready && !can_load;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= 16'd0;
            bit_idx    <= 3'd0;
            shift_reg  <= 8'd0;
            parity_bit <= 1'b0;
            stop_cnt   <= 1'b0;
            hold_data  <= 8'd0;
            tx_ready   <= 1'b1;
            tx_line    <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= frame_end;

            if (load) begin
                state      <= START;
                shift_reg  <= load_data;
                parity_bit <= (^load_data) ^ PAR_ODD;
                bit_cnt    <= BIT_LAST;
                bit_idx    <= 3'd0;
                tx_line    <= 1'b0;
                tx_busy    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        tx_line <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                    START: begin
                        if (bit_end) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                            bit_cnt <= BIT_LAST;
                            tx_line <= shift_reg[0];
                        end else begin
                            bit_cnt <= bit_cnt - 16'd1;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            bit_cnt <= BIT_LAST;
                            if (bit_idx == 3'd7) begin
                                if (PAR_EN) begin
                                    state   <= PARITY;
                                    tx_line <= parity_bit;
                                end else begin
                                    state    <= STOP;
                                    stop_cnt <= STOP_LAST;
                                    tx_line  <= 1'b1;
                                end
                            end else begin
                                bit_idx   <= bit_idx + 3'd1;
                                shift_reg <= {1'b0, shift_reg[7:1]};
                                tx_line   <= shift_reg[1];
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 16'd1;
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            state    <= STOP;
                            stop_cnt <= STOP_LAST;
                            bit_cnt  <= BIT_LAST;
                            tx_line  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt - 16'd1;
                        end
                    end
                    STOP: begin
                        if (frame_end) begin
                            state   <= IDLE;
                            tx_line <= 1'b1;
                            tx_busy <= 1'b0;
                        end else if (bit_end) begin
                            stop_cnt <= 1'b0;
                            bit_cnt  <= BIT_LAST;
                        end else begin
                            bit_cnt <= bit_cnt - 16'd1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        tx_line <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                endcase
            end

            if (load_hold) begin
                tx_ready <= 1'b1;
            end else if (queue) begin
                tx_ready  <= 1'b0;
                hold_data <= tx_data;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 10 clocks per bit across 8N1, even/odd parity and 2-stop builds.
// Expected waveforms come from a small frame model filled in per test.
module tb_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [3:0] start_v;
    logic [7:0] data_v [4];
    logic [3:0] ready_v, line_v, busy_v, done_v;

    uart_tx #(.clk_freq(1000000), .baud_rate(100000), .parity_en(0), .parity_odd(0), .stop_bits(1)) u_8n1 (
        .clk(clk), .reset_n(reset_n), .tx_data(data_v[0]), .tx_start(start_v[0]),
        .tx_ready(ready_v[0]), .tx_line(line_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
    uart_tx #(.clk_freq(1000000), .baud_rate(100000), .parity_en(1), .parity_odd(0), .stop_bits(1)) u_8e1 (
        .clk(clk), .reset_n(reset_n), .tx_data(data_v[1]), .tx_start(start_v[1]),
        .tx_ready(ready_v[1]), .tx_line(line_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
    uart_tx #(.clk_freq(1000000), .baud_rate(100000), .parity_en(1), .parity_odd(1), .stop_bits(1)) u_8o1 (
        .clk(clk), .reset_n(reset_n), .tx_data(data_v[2]), .tx_start(start_v[2]),
        .tx_ready(ready_v[2]), .tx_line(line_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));
    uart_tx #(.clk_freq(1000000), .baud_rate(100000), .parity_en(0), .parity_odd(0), .stop_bits(2)) u_8n2 (
        .clk(clk), .reset_n(reset_n), .tx_data(data_v[3]), .tx_start(start_v[3]),
        .tx_ready(ready_v[3]), .tx_line(line_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    localparam int N = 256;
    logic       rec_line [N], rec_busy [N], rec_ready [N], rec_done [N];
    logic       exp_line [N], exp_busy [N], exp_ready [N], exp_done [N];
    logic       sch_start [N];
    logic [7:0] sch_data [N];

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            exp_line[i]  = 1'b1;
            exp_busy[i]  = 1'b0;
            exp_ready[i] = 1'b1;
            exp_done[i]  = 1'b0;
            sch_start[i] = 1'b0;
            sch_data[i]  = 8'h00;
        end
    endtask

    // Frame model: cycle c0 is the first cycle after the accepting edge.
    task automatic add_frame(input int c0, input logic [7:0] d, input int pen, input int podd, input int nstop);
        int   nb;
        logic b;
        nb = 10 + pen + nstop - 1;
        for (int k = 0; k < nb; k++) begin
            if (k == 0)                    b = 1'b0;
            else if (k <= 8)               b = d[k-1];
            else if (pen != 0 && k == 9)   b = (^d) ^ (podd != 0);
            else                           b = 1'b1;
            for (int j = 0; j < 10; j++) begin
                exp_line[c0 + 10*k + j] = b;
                exp_busy[c0 + 10*k + j] = 1'b1;
            end
        end
        exp_done[c0 + 10*nb] = 1'b1;
    endtask

    // Accept d on DUT sel, then record n cycles, each sampled 1 time unit after an edge.
    task automatic send_and_record(input int sel, input logic [7:0] d, input int n);
        @(negedge clk);
        start_v[sel] = 1'b1;
        data_v[sel]  = d;
        @(posedge clk);
        #1;
        for (int c = 0; c < n; c++) begin
            rec_line[c]  = line_v[sel];
            rec_busy[c]  = busy_v[sel];
            rec_ready[c] = ready_v[sel];
            rec_done[c]  = done_v[sel];
            if (c + 1 < N && sch_start[c+1]) begin
                start_v[sel] = 1'b1;
                data_v[sel]  = sch_data[c+1];
            end else begin
                start_v[sel] = 1'b0;
                data_v[sel]  = ~d;
            end
            @(posedge clk);
            #1;
        end
        start_v[sel] = 1'b0;
    endtask

    task automatic compare(input string name, input int n);
        int bl, bb, br, bd, fl;
        bl = 0; bb = 0; br = 0; bd = 0; fl = -1;
        for (int c = 0; c < n; c++) begin
            if (rec_line[c] !== exp_line[c]) begin
                bl++;
                if (fl < 0) fl = c;
            end
            if (rec_busy[c]  !== exp_busy[c])  bb++;
            if (rec_ready[c] !== exp_ready[c]) br++;
            if (rec_done[c]  !== exp_done[c])  bd++;
        end
        check($sformatf("%s line cycles wrong (first %0d)", name, fl), bl, 0);
        check({name, " busy cycles wrong"}, bb, 0);
        check({name, " ready cycles wrong"}, br, 0);
        check({name, " done cycles wrong"}, bd, 0);
    endtask

    function automatic int count_high_busy(input int n);
        int s = 0;
        for (int c = 0; c < n; c++) if (rec_busy[c] === 1'b1) s++;
        return s;
    endfunction

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] seq;
        int         cnt, first;

        start_v = 4'b0;
        for (int i = 0; i < 4; i++) data_v[i] = 8'h00;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #16;
        check("reset outputs", {line_v, ready_v, busy_v, done_v}, 16'hFF00);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // 1: single byte 8N1
        clear_model();
        add_frame(0, 8'hA5, 0, 0, 1);
        send_and_record(0, 8'hA5, 106);
        compare("t1", 106);
        for (int k = 0; k < 10; k++) seq[k] = rec_line[10*k + 5];
        check("t1 bit sequence", seq, 10'h34A);
        check("t1 busy length", count_high_busy(106), 100);
        check("t1 done at 100", rec_done[100], 1'b1);
        repeat (5) @(posedge clk);

        // 2: parity
        clear_model();
        add_frame(0, 8'hA5, 1, 0, 1);
        send_and_record(1, 8'hA5, 116);
        compare("t2 even A5", 116);
        check("t2 even A5 parity", rec_line[95], 1'b0);
        check("t2 frame length", count_high_busy(116), 110);
        clear_model();
        add_frame(0, 8'hA5, 1, 1, 1);
        send_and_record(2, 8'hA5, 116);
        compare("t2 odd A5", 116);
        check("t2 odd A5 parity", rec_line[95], 1'b1);
        clear_model();
        add_frame(0, 8'h07, 1, 0, 1);
        send_and_record(1, 8'h07, 116);
        compare("t2 even 07", 116);
        check("t2 even 07 parity", rec_line[95], 1'b1);
        repeat (5) @(posedge clk);

        // 3: back-to-back with an ignored third request
        clear_model();
        add_frame(0, 8'h55, 0, 0, 1);
        add_frame(100, 8'h0F, 0, 0, 1);
        for (int c = 1; c < 100; c++) exp_ready[c] = 1'b0;
        sch_start[1]  = 1'b1; sch_data[1]  = 8'h0F;
        sch_start[2]  = 1'b1; sch_data[2]  = 8'hFF;
        sch_start[50] = 1'b1; sch_data[50] = 8'hFF;
        sch_start[99] = 1'b1; sch_data[99] = 8'hFF;
        send_and_record(0, 8'h55, 206);
        compare("t3", 206);
        first = -1;
        for (int c = 90; c < 120; c++) if (first < 0 && rec_line[c] === 1'b0) first = c;
        check("t3 second start cycle", first, 100);
        check("t3 busy length", count_high_busy(206), 200);
        repeat (5) @(posedge clk);

        // 6: accept in the exact last cycle of a frame
        clear_model();
        add_frame(0, 8'hA5, 0, 0, 1);
        add_frame(100, 8'h3C, 0, 0, 1);
        sch_start[100] = 1'b1; sch_data[100] = 8'h3C;
        send_and_record(0, 8'hA5, 206);
        compare("t6", 206);
        repeat (5) @(posedge clk);

        // 4: two stop bits
        clear_model();
        add_frame(0, 8'h00, 0, 0, 2);
        send_and_record(3, 8'h00, 116);
        compare("t4", 116);
        cnt = 0;
        for (int c = 0; c < 116; c++) if (rec_line[c] === 1'b0) cnt++;
        check("t4 low cycles", cnt, 90);
        check("t4 done at 110", rec_done[110], 1'b1);
        repeat (5) @(posedge clk);

        // 5: reset during d3 of 0xC3 with 0x11 queued
        clear_model();
        add_frame(0, 8'hC3, 0, 0, 1);
        for (int c = 1; c < 45; c++) exp_ready[c] = 1'b0;
        sch_start[1] = 1'b1; sch_data[1] = 8'h11;
        send_and_record(0, 8'hC3, 45);
        compare("t5 pre-reset", 45);
        #2 reset_n = 1'b0;
        #1;
        check("t5 async line/ready/busy/done", {line_v[0], ready_v[0], busy_v[0], done_v[0]}, 4'b1100);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (line_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || ready_v[0] !== 1'b1) cnt++;
        end
        check("t5 non-idle cycles after reset", cnt, 0);
        clear_model();
        add_frame(0, 8'h5A, 0, 0, 1);
        send_and_record(0, 8'h5A, 106);
        compare("t5 after reset", 106);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
